uart_rx_cmd_ctrl: RTL and testbench

UART_RX_CMD_CTRL -- requirements
Module: uart_rx_cmd_ctrl

---
 rtl/uart_rx_cmd_ctrl.sv | 149 ++++++++++++++
 tb/tb_uart_rx_cmd_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cmd_ctrl.sv
// Framed UART command receiver: SOF, CMD, LEN, payload, XOR checksum; holds a good frame until cmd_ready.
// Registered outputs (pay_data is a combinational buffer read); bytes arriving while a command is held are dropped with err_overrun.
module uart_rx_cmd_ctrl #(
  parameter int         MAX_LEN        = 8,
  parameter int         TIMEOUT_CYCLES = 5000,
  parameter logic [7:0] SOF            = 8'hAA
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_code,
  output logic [3:0] cmd_len,
  input  logic [3:0] pay_addr,
  output logic [7:0] pay_data,
  output logic       err_csum,
  output logic       err_len,
  output logic       err_timeout,
  output logic       err_overrun,
  output logic       busy
);

  localparam int            TW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CSUM, S_HOLD} state_t;

  state_t        state_q;
  logic [7:0]    code_q, csum_q, cmd_code_q;
  logic [3:0]    len_q, idx_q, cmd_len_q;
  logic [TW-1:0] tcnt_q;
  logic          cmd_valid_q, busy_q;
  logic          err_csum_q, err_len_q, err_timeout_q, err_overrun_q;
  logic [7:0]    buf_q [16];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      code_q        <= 8'h00;
      csum_q        <= 8'h00;
      cmd_code_q    <= 8'h00;
      len_q         <= 4'd0;
      idx_q         <= 4'd0;
      cmd_len_q     <= 4'd0;
      tcnt_q        <= '0;
      cmd_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      err_csum_q    <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      err_csum_q    <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tcnt_q <= '0;
          if (rx_valid && rx_data == SOF) begin
            state_q <= S_CMD;
            busy_q  <= 1'b1;
          end
        end
        S_HOLD: begin
          tcnt_q <= '0;
          if (rx_valid) err_overrun_q <= 1'b1;
          if (cmd_ready) begin
            state_q     <= S_IDLE;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          // A byte on the terminal count wins over the timeout.
          if (rx_valid) begin
            tcnt_q <= '0;
            case (state_q)
              S_CMD: begin
                code_q  <= rx_data;
                csum_q  <= rx_data;
                state_q <= S_LEN;
              end
              S_LEN: begin
                csum_q <= csum_q ^ rx_data;
                if (rx_data[7:4] != 4'd0 || rx_data > MAX_LEN_B) begin
                  err_len_q <= 1'b1;
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
                end else if (rx_data == 8'h00) begin
                  len_q   <= 4'd0;
                  state_q <= S_CSUM;
                end else begin
                  len_q   <= rx_data[3:0];
                  idx_q   <= 4'd0;
                  state_q <= S_PAYLOAD;
                end
              end
              S_PAYLOAD: begin
                csum_q <= csum_q ^ rx_data;
                idx_q  <= idx_q + 4'd1;
                if (idx_q == len_q - 4'd1) state_q <= S_CSUM;
              end
              S_CSUM: begin
                if (rx_data == csum_q) begin
                  state_q     <= S_HOLD;
                  cmd_valid_q <= 1'b1;
                  cmd_code_q  <= code_q;
                  cmd_len_q   <= len_q;
                end else begin
                  err_csum_q <= 1'b1;
                  state_q    <= S_IDLE;
                  busy_q     <= 1'b0;
                end
              end
              default: state_q <= S_IDLE;
            endcase
          end else if (tcnt_q == T_LAST) begin
            err_timeout_q <= 1'b1;
            tcnt_q        <= '0;
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Payload storage carries no reset; reads are gated by cmd_len instead.
  always_ff @(posedge clk) begin
    if (state_q == S_PAYLOAD && rx_valid) buf_q[idx_q] <= rx_data;
  end

  assign pay_data    = (pay_addr < cmd_len_q) ? buf_q[pay_addr] : 8'h00;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign cmd_len     = cmd_len_q;
  assign busy        = busy_q;
  assign err_csum    = err_csum_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Scoreboard bench for uart_rx_cmd_ctrl: stimulus pushes expected events, a monitor pops them as the DUT reports.
module tb_uart_rx_cmd_ctrl;

  localparam int EV_CMD = 0, EV_CSUM = 1, EV_LEN = 2, EV_TMO = 3, EV_OVR = 4;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    int         kind;
    logic [7:0] code;
    logic [3:0] len;
    logic [7:0] pay [16];
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       cmd_ready = 1'b0;
  logic [3:0] pay_addr = 4'd0;
  logic       cmd_valid, busy, err_csum, err_len, err_timeout, err_overrun;
  logic [7:0] cmd_code, pay_data;
  logic [3:0] cmd_len;

  ev_t exp_q [$];
  int  checks = 0;
  int  errors = 0;
  bq_t none;

  always #50 clk = ~clk;

  uart_rx_cmd_ctrl dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code), .cmd_len(cmd_len),
    .pay_addr(pay_addr), .pay_data(pay_data),
    .err_csum(err_csum), .err_len(err_len), .err_timeout(err_timeout), .err_overrun(err_overrun),
    .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] code, input logic [3:0] len, input bq_t pl);
    ev_t e;
    e.kind = kind;
    e.code = code;
    e.len  = len;
    for (int i = 0; i < 16; i++) e.pay[i] = (i < pl.size()) ? pl[i] : 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input bq_t b);
    foreach (b[i]) begin
      rx_data  = b[i];
      rx_valid = 1'b1;
      step(1);
      rx_valid = 1'b0;
    end
  endtask

  task automatic accept();
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
  endtask

  task automatic observe(input int kind, output ev_t e);
    e.kind = -1;
    e.code = 8'h00;
    e.len  = 4'd0;
    for (int i = 0; i < 16; i++) e.pay[i] = 8'h00;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d, expected no event", kind);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == EV_CMD && e.kind == EV_CMD) begin
        check("cmd_code", cmd_code, e.code);
        check("cmd_len", cmd_len, e.len);
        for (int i = 0; i < 16; i++) begin
          pay_addr = 4'(i);
          #1;
          check($sformatf("pay_data[%0d]", i), pay_data, e.pay[i]);
        end
      end
    end
  endtask

  // Monitor: every strobe and every rising cmd_valid must match the next expected event.
  initial begin
    ev_t  held, tmp;
    logic prev_vld;
    int   nstb;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_vld = 1'b0;
      end else begin
        nstb = int'(err_csum) + int'(err_len) + int'(err_timeout) + int'(err_overrun);
        if (nstb > 0) check("strobe_exclusive", nstb, 1);
        if (err_csum)    observe(EV_CSUM, tmp);
        if (err_len)     observe(EV_LEN, tmp);
        if (err_timeout) observe(EV_TMO, tmp);
        if (err_overrun) observe(EV_OVR, tmp);
        if (cmd_valid && !prev_vld) begin
          observe(EV_CMD, held);
        end else if (cmd_valid) begin
          check("hold_code", cmd_code, held.code);
          check("hold_len", cmd_len, held.len);
          pay_addr = 4'd0;
          #1;
          check("hold_pay0", pay_data, held.pay[0]);
        end
        prev_vld = cmd_valid;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(2);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_cmd_code", cmd_code, 8'h00);
    check("rst_cmd_len", cmd_len, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_errs", {err_csum, err_len, err_timeout, err_overrun}, 4'b0000);
    check("rst_pay_data", pay_data, 8'h00);
    reset = 1'b1;
    step(2);

    // Noise in IDLE is discarded silently.
    send('{8'h55, 8'h00});
    step(2);
    check("idle_noise_busy", busy, 1'b0);

    // Good frame: 10^02^41^42 = 11.
    expect_ev(EV_CMD, 8'h10, 4'd2, '{8'h41, 8'h42});
    send('{8'hAA});
    check("busy_after_sof", busy, 1'b1);
    send('{8'h10, 8'h02, 8'h41, 8'h42, 8'h11});
    check("vld_after_csum", cmd_valid, 1'b1);
    accept();
    check("vld_fall_after_accept", cmd_valid, 1'b0);
    check("busy_after_accept", busy, 1'b0);

    expect_ev(EV_CSUM, 8'h00, 4'd0, none);
    send('{8'hAA, 8'h10, 8'h02, 8'h41, 8'h42, 8'h00});
    step(2);
    check("csum_err_busy", busy, 1'b0);
    check("csum_err_vld", cmd_valid, 1'b0);

    expect_ev(EV_LEN, 8'h00, 4'd0, none);
    send('{8'hAA, 8'h05, 8'h09});
    check("err_len_cycle", err_len, 1'b1);
    check("len_err_busy", busy, 1'b0);

    expect_ev(EV_CMD, 8'h05, 4'd0, none);
    send('{8'hAA, 8'h05, 8'h00, 8'h05});
    accept();

    expect_ev(EV_LEN, 8'h00, 4'd0, none);
    send('{8'hAA, 8'h05, 8'h10});
    step(2);

    // MAX_LEN payload: 33^08^(01..08 xor = 08) = 33.
    expect_ev(EV_CMD, 8'h33, 4'd8, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});
    send('{8'hAA, 8'h33, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h33});
    accept();

    // SOF inside a frame is plain data: AA^01^AA = 01.
    expect_ev(EV_CMD, 8'hAA, 4'd1, '{8'hAA});
    send('{8'hAA, 8'hAA, 8'h01, 8'hAA, 8'h01});
    accept();

    send('{8'hAA, 8'h10});
    step(4999);
    check("tmo_not_yet_busy", busy, 1'b1);
    check("tmo_not_yet_strobe", err_timeout, 1'b0);
    expect_ev(EV_TMO, 8'h00, 4'd0, none);
    step(1);
    check("tmo_strobe", err_timeout, 1'b1);
    check("tmo_busy", busy, 1'b0);

    // Byte exactly on the terminal count is processed.
    send('{8'hAA, 8'h10});
    step(4999);
    expect_ev(EV_CMD, 8'h10, 4'd0, none);
    send('{8'h00, 8'h10});
    accept();

    // Overrun while holding, then on the accept cycle: 20^01^5A = 7B.
    expect_ev(EV_CMD, 8'h20, 4'd1, '{8'h5A});
    send('{8'hAA, 8'h20, 8'h01, 8'h5A, 8'h7B});
    step(3);
    expect_ev(EV_OVR, 8'h00, 4'd0, none);
    send('{8'hAA});
    check("ovr_vld_held", cmd_valid, 1'b1);
    check("ovr_code_held", cmd_code, 8'h20);
    step(2);
    expect_ev(EV_OVR, 8'h00, 4'd0, none);
    cmd_ready = 1'b1;
    send('{8'hAA});
    cmd_ready = 1'b0;
    check("ovr_accept_vld", cmd_valid, 1'b0);
    check("ovr_accept_busy", busy, 1'b0);

    send('{8'hAA, 8'h20, 8'h03, 8'h01});
    reset = 1'b0;
    #1;
    check("midrst_vld", cmd_valid, 1'b0);
    check("midrst_code", cmd_code, 8'h00);
    check("midrst_len", cmd_len, 4'd0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_errs", {err_csum, err_len, err_timeout, err_overrun}, 4'b0000);
    check("midrst_pay", pay_data, 8'h00);
    step(2);
    reset = 1'b1;
    step(6000);
    check("post_rst_busy", busy, 1'b0);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
